// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command sequencer: FSM encodings,
// status codes returned to the host and the default frame marker.
package alu_cmd_pkg;

    // 4-bit state encodings
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_GET_OP    = 4'd1;
    localparam logic [3:0] S_GET_A     = 4'd2;
    localparam logic [3:0] S_GET_B     = 4'd3;
    localparam logic [3:0] S_GET_CHK   = 4'd4;
    localparam logic [3:0] S_EXEC      = 4'd5;
    localparam logic [3:0] S_SEND_RES  = 4'd6;
    localparam logic [3:0] S_WAIT_RES  = 4'd7;
    localparam logic [3:0] S_SEND_STAT = 4'd8;
    localparam logic [3:0] S_WAIT_STAT = 4'd9;

    typedef enum logic [3:0] {
        IDLE      = S_IDLE,
        GET_OP    = S_GET_OP,
        GET_A     = S_GET_A,
        GET_B     = S_GET_B,
        GET_CHK   = S_GET_CHK,
        EXEC      = S_EXEC,
        SEND_RES  = S_SEND_RES,
        WAIT_RES  = S_WAIT_RES,
        SEND_STAT = S_SEND_STAT,
        WAIT_STAT = S_WAIT_STAT
    } state_t;

    // Status byte values sent after every frame
    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CHK = 8'hE1;
    localparam logic [7:0] ST_TMO = 8'hE2;
    localparam logic [7:0] ST_OPC = 8'hE3;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/alu_cmd_timeout.sv
// Inter-byte timeout: counts baud sample ticks while enabled and pulses
// expire on the tick that completes TIMEOUT_TICKS ticks without a clear.
module alu_cmd_timeout #(
    parameter int                NB_TMO        = 16,
    parameter logic [NB_TMO-1:0] TIMEOUT_TICKS = 16'd2048
) (
    input  logic clk,
    input  logic srst,
    input  logic enable,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam logic [NB_TMO-1:0] LAST_COUNT = TIMEOUT_TICKS - NB_TMO'(1);

    logic [NB_TMO-1:0] count_reg;
    logic [NB_TMO-1:0] count_next;

    // A clear in the same cycle as the final tick suppresses the expiry
    assign expire = enable & tick & ~clear & (count_reg == LAST_COUNT);

    // Next count: held at zero while disabled so every enable starts fresh
    always_comb begin
        count_next = count_reg;
        if (clear || !enable) begin
            count_next = '0;
        end else if (tick) begin
            count_next = expire ? '0 : count_reg + NB_TMO'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Framed command controller: collects sync/op/A/B/checksum from the UART
// receiver, drives the ALU, and returns result and status bytes through
// the UART transmitter using its done handshake.
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int           NB_DATA       = 8,
    parameter int           NB_OP         = 6,
    parameter logic [7:0]   SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int           NB_TMO        = 16,
    parameter logic [15:0]  TIMEOUT_TICKS = 16'd2048
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_frame_error
);

    state_t             state_reg, state_next;
    logic [NB_DATA-1:0] op_s_reg, op_s_next;
    logic [NB_DATA-1:0] a_s_reg, a_s_next;
    logic [NB_DATA-1:0] b_s_reg, b_s_next;
    logic [NB_DATA-1:0] data_a_reg, data_a_next;
    logic [NB_DATA-1:0] data_b_reg, data_b_next;
    logic [NB_OP-1:0]   operation_reg, operation_next;
    logic [NB_DATA-1:0] result_reg, result_next;
    logic [NB_DATA-1:0] status_reg, status_next;
    logic               frame_error_reg, frame_error_next;

    logic in_get;
    logic tmo_expire;

    assign in_get = (state_reg == GET_OP) || (state_reg == GET_A) ||
                    (state_reg == GET_B)  || (state_reg == GET_CHK);

    // Counter is held at zero outside the GET states, so entering GET_OP
    // always starts from zero; each received byte restarts it.
    alu_cmd_timeout #(
        .NB_TMO        (NB_TMO),
        .TIMEOUT_TICKS (NB_TMO'(TIMEOUT_TICKS))
    ) u_timeout (
        .clk    (i_clock),
        .srst   (i_reset),
        .enable (in_get),
        .clear  (i_rx_done_tick),
        .tick   (i_s_tick),
        .expire (tmo_expire)
    );

    // Next-state and datapath updates; rx bytes outside IDLE/GET_* are dropped
    always_comb begin
        state_next       = state_reg;
        op_s_next        = op_s_reg;
        a_s_next         = a_s_reg;
        b_s_next         = b_s_reg;
        data_a_next      = data_a_reg;
        data_b_next      = data_b_reg;
        operation_next   = operation_reg;
        result_next      = result_reg;
        status_next      = status_reg;
        frame_error_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_rx_done_tick && (i_rx_data == SYNC_BYTE[NB_DATA-1:0])) begin
                    state_next = GET_OP;
                end
            end
            GET_OP, GET_A, GET_B: begin
                if (i_rx_done_tick) begin
                    if (state_reg == GET_OP) begin
                        op_s_next  = i_rx_data;
                        state_next = GET_A;
                    end else if (state_reg == GET_A) begin
                        a_s_next   = i_rx_data;
                        state_next = GET_B;
                    end else begin
                        b_s_next   = i_rx_data;
                        state_next = GET_CHK;
                    end
                end else if (tmo_expire) begin
                    status_next      = ST_TMO;
                    frame_error_next = 1'b1;
                    state_next       = SEND_STAT;
                end
            end
            GET_CHK: begin
                if (i_rx_done_tick) begin
                    if (i_rx_data != (op_s_reg ^ a_s_reg ^ b_s_reg)) begin
                        status_next      = ST_CHK;
                        frame_error_next = 1'b1;
                        state_next       = SEND_STAT;
                    end else if (op_s_reg[NB_DATA-1:NB_OP] != '0) begin
                        status_next      = ST_OPC;
                        frame_error_next = 1'b1;
                        state_next       = SEND_STAT;
                    end else begin
                        data_a_next    = a_s_reg;
                        data_b_next    = b_s_reg;
                        operation_next = op_s_reg[NB_OP-1:0];
                        state_next     = EXEC;
                    end
                end else if (tmo_expire) begin
                    status_next      = ST_TMO;
                    frame_error_next = 1'b1;
                    state_next       = SEND_STAT;
                end
            end
            EXEC: begin
                // ALU operands have had a full cycle to settle
                result_next = i_alu_result;
                state_next  = SEND_RES;
            end
            SEND_RES:  state_next = WAIT_RES;
            WAIT_RES: begin
                if (i_tx_done_tick) begin
                    status_next = ST_OK;
                    state_next  = SEND_STAT;
                end
            end
            SEND_STAT: state_next = WAIT_STAT;
            WAIT_STAT: begin
                if (i_tx_done_tick) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg       <= IDLE;
            op_s_reg        <= '0;
            a_s_reg         <= '0;
            b_s_reg         <= '0;
            data_a_reg      <= '0;
            data_b_reg      <= '0;
            operation_reg   <= '0;
            result_reg      <= '0;
            status_reg      <= '0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_s_reg        <= op_s_next;
            a_s_reg         <= a_s_next;
            b_s_reg         <= b_s_next;
            data_a_reg      <= data_a_next;
            data_b_reg      <= data_b_next;
            operation_reg   <= operation_next;
            result_reg      <= result_next;
            status_reg      <= status_next;
            frame_error_reg <= frame_error_next;
        end
    end

    // Transmit side is a pure function of state; o_tx_data stays put through WAIT
    always_comb begin
        o_tx_start = (state_reg == SEND_RES) || (state_reg == SEND_STAT);
        o_busy     = !(in_get || (state_reg == IDLE));
        o_tx_data  = '0;
        if ((state_reg == SEND_RES) || (state_reg == WAIT_RES)) begin
            o_tx_data = result_reg;
        end else if ((state_reg == SEND_STAT) || (state_reg == WAIT_STAT)) begin
            o_tx_data = status_reg;
        end
    end

    assign o_data_a      = data_a_reg;
    assign o_data_b      = data_b_reg;
    assign o_operation   = operation_reg;
    assign o_frame_error = frame_error_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       s_tick;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] operation;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_error;

    int total = 0;
    int bad   = 0;
    int err_count  = 0;
    int tick_count = 0;

    alu_cmd_sequencer dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_s_tick       (s_tick),
        .i_rx_done_tick (rx_done),
        .i_rx_data      (rx_data),
        .i_tx_done_tick (tx_done),
        .i_alu_result   (alu_result),
        .o_data_a       (data_a),
        .o_data_b       (data_b),
        .o_operation    (operation),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .o_busy         (busy),
        .o_frame_error  (frame_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU
    always_comb begin
        case (operation)
            6'h20:   alu_result = data_a + data_b;
            6'h22:   alu_result = data_a - data_b;
            6'h24:   alu_result = data_a & data_b;
            6'h26:   alu_result = data_a ^ data_b;
            default: alu_result = 8'h00;
        endcase
    end

    // Baud tick every 4th cycle
    initial begin
        s_tick = 1'b0;
        for (int ph = 0; ; ph = (ph + 1) % 4) begin
            @(negedge clk);
            s_tick = (ph == 3);
        end
    end

    always @(posedge clk) begin
        if (s_tick) tick_count <= tick_count + 1;
        if (frame_error) err_count <= err_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rx byte; returns at the negedge after the DUT sampled it
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(a);
        send_byte(b);
        send_byte(chk);
    endtask

    // Wait for a tx request, check its byte, hold done off, then acknowledge
    task automatic expect_tx(input logic [7:0] exp, input string tag, input int hold);
        int waited = 0;
        int extra  = 0;
        int drift  = 0;
        while (!tx_start && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_start"}, 32'(tx_start), 32'd1);
        check({tag, "_data"}, 32'(tx_data), 32'(exp));
        $display("tx %s byte=%0h after %0d cycles", tag, tx_data, waited);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (tx_start) extra++;
            if (tx_data !== exp) drift++;
        end
        check({tag, "_extra_start"}, 32'(extra), 32'd0);
        check({tag, "_hold"}, 32'(drift), 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int starts = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        check({tag, "_quiet"}, 32'(starts), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int e0;
        int snap;
        int waited;
        int starts;
        int drift;
        logic [7:0] junk [5];

        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a", 32'(data_a), 32'h0);
        check("rst_b", 32'(data_b), 32'h0);
        check("rst_op", 32'(operation), 32'h0);
        check("rst_start", 32'(tx_start), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(frame_error), 32'h0);
        rst = 1'b0;

        // Noise before sync, then add command
        send_byte(8'h00);
        send_byte(8'hFF);
        check("noise_busy", 32'(busy), 32'h0);
        send_frame(8'h20, 8'h05, 8'h03, 8'h26);
        check("add_lat1", 32'(tx_start), 32'h0);
        check("add_a", 32'(data_a), 32'h05);
        check("add_b", 32'(data_b), 32'h03);
        check("add_op", 32'(operation), 32'h20);
        check("add_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("add_lat2", 32'(tx_start), 32'h1);
        expect_tx(8'h08, "add_res", 3);
        expect_tx(8'h00, "add_stat", 2);
        expect_quiet("add", 5);
        check("add_noerr", 32'(err_count), 32'd0);

        // Bad checksum (correct would be 31): ALU outputs must hold
        e0 = err_count;
        send_frame(8'h22, 8'h10, 8'h03, 8'h30);
        check("chk_pulse", 32'(frame_error), 32'h1);
        expect_tx(8'hE1, "chk_stat", 2);
        expect_quiet("chk", 20);
        check("chk_errcnt", 32'(err_count), 32'(e0 + 1));
        check("chk_hold_a", 32'(data_a), 32'h05);
        check("chk_hold_b", 32'(data_b), 32'h03);
        check("chk_hold_op", 32'(operation), 32'h20);

        // Bad opcode with a valid checksum
        e0 = err_count;
        send_frame(8'hC0, 8'h01, 8'h01, 8'hC0);
        expect_tx(8'hE3, "opc_stat", 2);
        expect_quiet("opc", 20);
        check("opc_errcnt", 32'(err_count), 32'(e0 + 1));
        check("opc_hold_op", 32'(operation), 32'h20);

        // Timeout after sync + opcode
        e0 = err_count;
        send_byte(8'hA5);
        send_byte(8'h20);
        snap = tick_count;
        waited = 0;
        while (!frame_error && waited < 12000) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_seen", 32'(frame_error), 32'h1);
        check("tmo_ticks", 32'(tick_count - snap), 32'd2048);
        expect_tx(8'hE2, "tmo_stat", 2);
        expect_quiet("tmo", 10);
        check("tmo_errcnt", 32'(err_count), 32'(e0 + 1));

        // Long handshake with bytes injected while waiting
        junk[0] = 8'hA5; junk[1] = 8'h20; junk[2] = 8'h05; junk[3] = 8'h03; junk[4] = 8'h26;
        send_frame(8'h22, 8'h10, 8'h03, 8'h31);
        @(negedge clk);
        check("hs_start", 32'(tx_start), 32'h1);
        check("hs_res", 32'(tx_data), 32'h0D);
        starts = 0;
        drift  = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
            if (tx_data !== 8'h0D) drift++;
            if (i >= 100 && i < 105) begin
                rx_done = 1'b1;
                rx_data = junk[i - 100];
            end else begin
                rx_done = 1'b0;
            end
        end
        check("hs_no_restart", 32'(starts), 32'd0);
        check("hs_hold", 32'(drift), 32'd0);
        check("hs_busy", 32'(busy), 32'h1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        expect_tx(8'h00, "hs_stat", 2);
        expect_quiet("hs", 10);
        send_frame(8'h24, 8'h0F, 8'h3C, 8'h17);
        expect_tx(8'h0C, "and_res", 1);
        expect_tx(8'h00, "and_stat", 1);
        check("and_a", 32'(data_a), 32'h0F);

        // Reset during GET_B
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h05);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_a", 32'(data_a), 32'h0);
        check("mid_rst_op", 32'(operation), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        send_byte(8'h03);
        expect_quiet("mid_rst", 5);
        send_frame(8'h26, 8'h0A, 8'h0C, 8'h20);
        expect_tx(8'h06, "xor_res", 1);
        expect_tx(8'h00, "xor_stat", 1);
        check("xor_op", 32'(operation), 32'h26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
